ex_operand_stage: RTL

ID/EX pipeline register and operand-forwarding stage that sits directly upstream of the EX-stage ALU. It latches decoded instruction fields from ID and resolves RAW hazards by forwarding from EX/MEM and MEM/WB. It then drives the ALU's control code, sign flag and both 32-bit operands. It also supplies forwarded store data and write-back tags to the EX/MEM stage.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/fwd_mux.sv | 47 ++++
 rtl/ex_operand_stage.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
// Module : mips_pkg
// Brief  : Shared ALU op codes, forward-select codes and datapath defaults.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam int DEF_XLEN    = 32;
  localparam int DEF_RADDR_W = 5;

  typedef enum logic [4:0] {
    ALU_ADD = 5'd0,
    ALU_SUB = 5'd1,
    ALU_AND = 5'd2,
    ALU_OR  = 5'd3,
    ALU_XOR = 5'd4,
    ALU_NOR = 5'd5,
    ALU_SLL = 5'd6,
    ALU_SRL = 5'd7,
    ALU_SRA = 5'd8,
    ALU_SLT = 5'd9
  } alu_op_e;

  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_MEMWB = 2'd1;
  localparam logic [1:0] FWD_EXMEM = 2'd2;

endpackage

`default_nettype wire

// File: rtl/fwd_mux.sv
// ============================================================================
// Module : fwd_mux
// Brief  : Single-operand forwarding comparator and 3:1 operand mux.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fwd_mux
  import mips_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int RADDR_W = DEF_RADDR_W
) (
  input  logic [RADDR_W-1:0] src,
  input  logic [XLEN-1:0]    reg_data,
  input  logic               exmem_reg_write,
  input  logic [RADDR_W-1:0] exmem_rd,
  input  logic [XLEN-1:0]    exmem_result,
  input  logic               memwb_reg_write,
  input  logic [RADDR_W-1:0] memwb_rd,
  input  logic [XLEN-1:0]    memwb_result,
  output logic [XLEN-1:0]    data,
  output logic [1:0]         sel
);

  logic w_hit_exmem;
  logic w_hit_memwb;

  // r0 is hard-wired zero, so a producer targeting it never forwards.
  assign w_hit_exmem = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src);
  assign w_hit_memwb = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src);

  always_comb begin
    sel  = FWD_REG;
    data = reg_data;
    if (w_hit_exmem) begin
      sel  = FWD_EXMEM;
      data = exmem_result;
    end else if (w_hit_memwb) begin
      sel  = FWD_MEMWB;
      data = memwb_result;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ex_operand_stage.sv
// ============================================================================
// Module : ex_operand_stage
// Brief  : ID/EX register with EX/MEM and MEM/WB operand forwarding.
//          Forwarding and stall-refresh are built only when FORWARD_EN is set.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ex_operand_stage
  import mips_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int RADDR_W = DEF_RADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               id_valid,
  input  logic [4:0]         id_alu_ctrl,
  input  logic               id_sign,
  input  logic               id_src1_shamt,
  input  logic               id_src2_imm,
  input  logic [XLEN-1:0]    id_rs_data,
  input  logic [XLEN-1:0]    id_rt_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [4:0]         id_shamt,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic               id_reg_write,
  input  logic               exmem_reg_write,
  input  logic [RADDR_W-1:0] exmem_rd,
  input  logic [XLEN-1:0]    exmem_result,
  input  logic               memwb_reg_write,
  input  logic [RADDR_W-1:0] memwb_rd,
  input  logic [XLEN-1:0]    memwb_result,
  output logic               ex_valid,
  output logic [4:0]         ex_alu_ctrl,
  output logic               ex_sign,
  output logic [XLEN-1:0]    ex_in1,
  output logic [XLEN-1:0]    ex_in2,
  output logic [XLEN-1:0]    ex_store_data,
  output logic [RADDR_W-1:0] ex_rd,
  output logic               ex_reg_write,
  output logic [1:0]         ex_fwd_a,
  output logic [1:0]         ex_fwd_b
);

  logic               r_valid;
  logic [4:0]         r_alu_ctrl;
  logic               r_sign;
  logic               r_src1_shamt;
  logic               r_src2_imm;
  logic [XLEN-1:0]    r_rs_data;
  logic [XLEN-1:0]    r_rt_data;
  logic [XLEN-1:0]    r_imm;
  logic [4:0]         r_shamt;
  logic [RADDR_W-1:0] r_rs;
  logic [RADDR_W-1:0] r_rt;
  logic [RADDR_W-1:0] r_rd;
  logic               r_reg_write;

  logic [XLEN-1:0]    w_fwd_a;
  logic [XLEN-1:0]    w_fwd_b;
  logic [1:0]         w_sel_a;
  logic [1:0]         w_sel_b;

`ifdef FORWARD_EN
  fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_a (
    .src             (r_rs),
    .reg_data        (r_rs_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .data            (w_fwd_a),
    .sel             (w_sel_a)
  );

  fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_b (
    .src             (r_rt),
    .reg_data        (r_rt_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .data            (w_fwd_b),
    .sel             (w_sel_b)
  );
`else
  logic w_unused_fwd;

  assign w_fwd_a = r_rs_data;
  assign w_fwd_b = r_rt_data;
  assign w_sel_a = FWD_REG;
  assign w_sel_b = FWD_REG;
  assign w_unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_result,
                          memwb_reg_write, memwb_rd, memwb_result, r_rs, r_rt};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush_i) begin
      r_valid      <= 1'b0;
      r_alu_ctrl   <= ALU_ADD;
      r_sign       <= 1'b0;
      r_src1_shamt <= 1'b0;
      r_src2_imm   <= 1'b0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_shamt      <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
    end else if (stall_i) begin
`ifdef FORWARD_EN
      // Capture forwarded values so a producer retiring mid-stall is not lost.
      r_rs_data <= w_fwd_a;
      r_rt_data <= w_fwd_b;
`endif
    end else begin
      r_valid      <= id_valid;
      r_alu_ctrl   <= id_alu_ctrl;
      r_sign       <= id_sign;
      r_src1_shamt <= id_src1_shamt;
      r_src2_imm   <= id_src2_imm;
      r_rs_data    <= id_rs_data;
      r_rt_data    <= id_rt_data;
      r_imm        <= id_imm;
      r_shamt      <= id_shamt;
      r_rs         <= id_rs;
      r_rt         <= id_rt;
      r_rd         <= id_rd;
      r_reg_write  <= id_reg_write & id_valid;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_alu_ctrl   = r_alu_ctrl;
  assign ex_sign       = r_sign;
  assign ex_in1        = r_src1_shamt ? {{(XLEN-5){1'b0}}, r_shamt} : w_fwd_a;
  assign ex_in2        = r_src2_imm ? r_imm : w_fwd_b;
  assign ex_store_data = w_fwd_b;
  assign ex_rd         = r_valid ? r_rd : '0;
  assign ex_reg_write  = r_reg_write & r_valid;
  assign ex_fwd_a      = w_sel_a;
  assign ex_fwd_b      = w_sel_b;

endmodule

`default_nettype wire
